alu_arbiter: RTL
================

# alu_arbiter

Two-requester front end that time-shares one `ALU` instance (32-bit, 4-bit `alu_sel` encoding) between independent clients, e.g. the main pipeline's EX stage and a CSR/branch-target helper. The block arbitrates fairly between the clients and latches the winning operands. It computes the result in a dedicated execute cycle and holds the result with a per-requester valid/ready response handshake. At most one operation is in flight.

## Interface
Parameters:
- `FIRST_PRIO`, default 0: requester that wins the first arbitration after reset (0 or 1).

Ports (`n` = 0, 1; one set of request/response ports per requester):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rn_valid`  in  1  request n presents an operation.
- `rn_ready`  out  1  request n accepted this cycle when `rn_valid & rn_ready`.
- `rn_a`  in  32  operand A.
- `rn_b`  in  32  operand B.
- `rn_sel`  in  4  ALU op code, same encoding as `ALU`.
- `rn_res_valid`  out  1  result for requester n is available.
- `rn_res_ready`  in  1  requester n consumes the result.
- `rn_res`  out  32  result data; meaningful only while `rn_res_valid` is high.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- The FSM has three states:
  - IDLE -> EXEC on accept.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE on response handshake with no new accept.
  - RESP -> EXEC on response handshake with a same-cycle accept.
- Arbitration is evaluated whenever `ready` may be asserted, which is in IDLE, or in RESP with `r{owner}_res_ready` = 1.
  - Only one requester valid: it wins.
  - Both valid: the requester other than `last_owner` wins (round-robin).
  - `rn_ready` = eligible & `rn_valid` & granted-to-n.
  - `rn_ready` is never high for both requesters in the same cycle.
- On accept, the block latches `a`, `b`, `sel` and `owner`, and updates `last_owner` to the winner.
- In EXEC, the `ALU` is driven from the latched registers. `alu_res_o` is captured into `res_q` at the end of EXEC.
- In RESP:
  - `r{owner}_res_valid` = 1; the other requester's `res_valid` = 0.
  - Both `rn_res` outputs are driven from `res_q`.
  - `res_valid` and `res_q` hold until `r{owner}_res_ready`.
- Undefined `sel` values are passed through unchanged; the `ALU` returns 0 for them and that result is delivered normally.
- Request rule: once `rn_valid` is asserted, it and the operands stay stable until `rn_ready`. The arbiter re-evaluates every cycle, so a withdrawn request never locks the block.
- A requester that is not the owner keeps waiting in RESP until the owner drains its result.

## Timing
- Reset, asynchronous, applied at any point including mid-EXEC or mid-RESP:
  - state = IDLE, `last_owner` = 1 − `FIRST_PRIO`.
  - `res_q` = 0, both `res_valid` = 0, `busy` = 0.
  - The in-flight operation is dropped without a response.
  - Both `rn_ready` are forced to 0 while `rst` is high.
- Latency: accept at edge T gives `res_valid` high during cycle T+2, i.e. two cycles from the accept edge.
- Throughput with back-to-back requests and `res_ready` held high:
  - One accept every 2 cycles (RESP overlaps the next accept).
  - Both requesters continuously valid produces grants alternating 0, 1, 0, 1.
- `rn_ready` depends combinationally on `rn_valid`, state and `r{owner}_res_ready`. There is no combinational path from operand inputs to any output.
- `res_ready` asserted while `res_valid` is low is ignored.

## Structure
- Package `alu_arb_pkg` holds:
  - FSM state enum (IDLE, EXEC, RESP).
  - `ALU` op-code localparams: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1100, SRA 1101, PASSB 1111.
- Sub-module `rr_arb2`: combinational 2-way round-robin grant (inputs `req[1:0]`, `last_owner`, `en`; output `gnt[1:0]`).
- The top level instantiates `rr_arb2` and the existing `ALU` unchanged.

## Test plan
- Reset behaviour: assert `rst` with `r0_valid` = 1 -> `r0_ready` = 0 throughout reset. First accept after release goes to `FIRST_PRIO`. All `res_valid` = 0 and `busy` = 0 during reset.
- Single op: `r0` ADD a=5, b=7, `res_ready` = 1 -> `r0_res_valid` high 2 cycles after accept, `r0_res` = 12, `r1_res_valid` stays 0.
- Fairness: both requesters valid continuously, `r0` SUB 10−3, `r1` SRA 0x80000000>>>4 -> grants alternate. `r0` results = 7, `r1` results = 0xF8000000. One accept every 2 cycles.
- Backpressure: `r1` SLTU 1<2 with `r1_res_ready` = 0 for 5 cycles while `r0_valid` = 1 -> `r1_res` = 1 held stable and `r0_ready` = 0. On the `r1_res_ready` cycle, `r0` is accepted the same cycle.
- Undefined op: `r0_sel` = 1000, a=b=0xFFFFFFFF -> `r0_res` = 0, handshake completes normally.
- Reset mid-op: assert `rst` during EXEC -> no `res_valid` ever issued for that op. The next op after reset completes with the correct result.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and ALU op codes for the ALU arbiter
//
// Purpose: FSM state encoding and ALU op-code constants used by ALU and
//          alu_arbiter.
// Ports:   none (package).
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_PASSB = 4'b1111;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - 32-bit combinational ALU with 4-bit op select
//
// Purpose: computes one result from two operands; unknown op codes give 0.
// Ports:   operand_a, operand_b (32) in; alu_sel (4) in; alu_res_o (32) out.
module ALU
  import alu_arb_pkg::*;
(
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  alu_sel,
  output logic [31:0] alu_res_o
);

  always_comb begin
    alu_res_o = 32'd0;
    case (alu_sel)
      OP_ADD:   alu_res_o = operand_a + operand_b;
      OP_SLL:   alu_res_o = operand_a << operand_b[4:0];
      OP_SLT:   alu_res_o = {31'd0, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU:  alu_res_o = {31'd0, operand_a < operand_b};
      OP_XOR:   alu_res_o = operand_a ^ operand_b;
      OP_SRL:   alu_res_o = operand_a >> operand_b[4:0];
      OP_OR:    alu_res_o = operand_a | operand_b;
      OP_AND:   alu_res_o = operand_a & operand_b;
      OP_SUB:   alu_res_o = operand_a - operand_b;
      OP_SRA:   alu_res_o = $unsigned($signed(operand_a) >>> operand_b[4:0]);
      OP_PASSB: alu_res_o = operand_b;
      default:  alu_res_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin grant
//
// Purpose: grants one of two requesters; on contention the one that did not
//          win last time is chosen.
// Ports:   req (2) in; last_owner (1) in; en (1) in; gnt (2) out, one-hot or 0.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_owner ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester front end time-sharing one ALU
//
// Purpose: round-robin arbitration between two clients, operand latch,
//          one execute cycle, then a held per-requester result handshake.
// Ports:   clk, rst (async, active high);
//          rN_valid/rN_ready, rN_a, rN_b (32), rN_sel (4)  request side;
//          rN_res_valid/rN_res_ready, rN_res (32)           response side;
//          busy  high in EXEC or RESP.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int FIRST_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [3:0]  r0_sel,
  output logic        r0_res_valid,
  input  logic        r0_res_ready,
  output logic [31:0] r0_res,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [3:0]  r1_sel,
  output logic        r1_res_valid,
  input  logic        r1_res_ready,
  output logic [31:0] r1_res,
  output logic        busy
);

  localparam logic LAST_OWNER_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  state_t      state_q;
  logic        owner_q;
  logic        last_owner_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  sel_q;
  logic [31:0] res_q;
  logic [31:0] alu_res;
  logic [1:0]  gnt;
  logic        owner_res_ready;
  logic        eligible;
  logic        accept;
  logic        win;

  // A new accept may overlap the final RESP cycle once the owner drains.
  assign owner_res_ready = owner_q ? r1_res_ready : r0_res_ready;
  assign eligible = !rst && ((state_q == IDLE) ||
                             ((state_q == RESP) && owner_res_ready));

  rr_arb2 u_arb (
    .req        ({r1_valid, r0_valid}),
    .last_owner (last_owner_q),
    .en         (eligible),
    .gnt        (gnt)
  );

  assign accept   = |gnt;
  assign win      = gnt[1];
  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];

  ALU u_alu (
    .operand_a (a_q),
    .operand_b (b_q),
    .alu_sel   (sel_q),
    .alu_res_o (alu_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= LAST_OWNER_RST;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      sel_q        <= 4'd0;
      res_q        <= 32'd0;
    end else begin
      if (accept) begin
        owner_q      <= win;
        last_owner_q <= win;
        a_q          <= win ? r1_a   : r0_a;
        b_q          <= win ? r1_b   : r0_b;
        sel_q        <= win ? r1_sel : r0_sel;
      end
      case (state_q)
        IDLE: if (accept) state_q <= EXEC;
        EXEC: begin
          res_q   <= alu_res;
          state_q <= RESP;
        end
        RESP: if (owner_res_ready) state_q <= accept ? EXEC : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response flags come straight from registered state, so no input reaches them.
  assign r0_res_valid = (state_q == RESP) && !owner_q;
  assign r1_res_valid = (state_q == RESP) &&  owner_q;
  assign r0_res       = res_q;
  assign r1_res       = res_q;
  assign busy         = (state_q != IDLE);

endmodule
